ppdu_framer: RTL and testbench
==============================

# ppdu_framer

- Transmit-side framing stage that sits directly upstream of the inFIFO.
- On a start request it emits one complete IEEE 802.15.4 PPDU into the inFIFO as a stream of 4-bit symbols, one per write:
  - preamble (zero nibbles)
  - SFD
  - PHR (frame length)
  - payload nibbles pulled from a valid/ready source
- It obeys the inFIFO full flag, so the coder downstream receives symbols in correct over-the-air order with no host-side framing.

## Interface
Parameters:
- PREAMBLE_NIBBLES, 8, number of 4'h0 preamble symbols.
- SFD, 8'hA7, start-of-frame delimiter, sent low nibble first.

Ports:
- inClock  in  1  single clock; all logic on rising edge.
- inReset  in  1  synchronous, active-high reset.
- inStart  in  1  one-cycle frame start request; honoured only in IDLE.
- inLength  in  7  payload length in bytes (1..127); sampled when inStart is accepted.
- inPayData  in  4  payload nibble, low nibble of each byte first.
- inPayValid  in  1  payload source has a nibble on inPayData.
- outPayReady  out  1  framer accepts a payload nibble this cycle.
- inFifoFull  in  1  inFIFO full flag.
- outData  out  4  symbol to inFIFO data input.
- outWriteEnable  out  1  inFIFO write strobe; one symbol per asserted cycle.
- outBusy  out  1  frame in progress (state not IDLE).
- outDone  out  1  one-cycle pulse after the last payload write.
- outError  out  1  one-cycle pulse when inStart is rejected because inLength = 0.

## Operation
- States:
  - IDLE
  - PREAMBLE
  - SFD
  - PHR
  - PAYLOAD
  - DONE
- Internal registers: 8-bit nibble counter `cnt` and latched 7-bit length `len`.
- IDLE:
  - inStart=1 with inLength≠0: latch `len`, clear `cnt`, go to PREAMBLE.
  - inStart=1 with inLength=0: pulse outError next cycle, stay IDLE.
- Write rule for PREAMBLE, SFD and PHR:
  - `emit` = state in {PREAMBLE, SFD, PHR}.
  - outWriteEnable = emit & ~inFifoFull (combinational).
  - `cnt` advances only on an actual write.
- PREAMBLE:
  - outData = 4'h0.
  - After PREAMBLE_NIBBLES writes, clear `cnt` and go to SFD.
- SFD:
  - outData = SFD[3:0] when cnt=0, SFD[7:4] when cnt=1.
  - After 2 writes go to PHR.
- PHR:
  - outData = len[3:0] when cnt=0, {1'b0, len[6:4]} when cnt=1.
  - After 2 writes go to PAYLOAD.
- PAYLOAD:
  - outPayReady = ~inFifoFull.
  - outWriteEnable = inPayValid & ~inFifoFull.
  - outData = inPayData (combinational pass-through).
  - After 2·len writes go to DONE.
- DONE: outDone=1 for one cycle, then IDLE.
- Total writes per frame: PREAMBLE_NIBBLES + 4 + 2·len.
- inStart outside IDLE is ignored. No queuing.
- inFifoFull=1 stalls every state with no symbol lost or duplicated. Stall length is unbounded.
- inPayValid low in PAYLOAD stalls; no timeout.

## Timing
- Reset values: state IDLE, cnt 0, len 0, all outputs 0 (outData 4'h0).
- inReset=1 at any edge, including mid-frame: IDLE on the next cycle. The partial frame is abandoned (no flush), and outDone/outError are not pulsed.
- Accepted inStart at edge T:
  - outBusy=1 from T+1.
  - First preamble write in cycle T+1 if inFifoFull=0.
- No backpressure, payload always valid:
  - Last write in cycle T+PREAMBLE_NIBBLES+4+2·len.
  - outDone in the following cycle; IDLE one cycle later.
  - A new inStart is accepted in that IDLE cycle.
- inFifoFull is sampled combinationally in the same cycle as the write. Writes never occur while the FIFO is full.
- inFifoFull rising on the cycle of the final write of a state does not block that write if it was 0 in that cycle. The state transition happens on the write, not on the flag.

## Structure
- Shared package zigbee_pkg gets:
  - framer state enum
  - SFD default 8'hA7
  - PREAMBLE_NIBBLES default
  - MAX_PSDU_LEN = 127
- Single module, no sub-module. The counter and mux are small enough to stay inline.
- Instantiated in TOP ahead of the inFIFO write port. Its outputs join the existing MUX/DEMUX test selection like the other stand-alone stages.

## Test plan
- Basic frame, len=1, source [0x3,0x5], FIFO never full → 14 writes in 14 consecutive cycles: 0,0,0,0,0,0,0,0,7,A,1,0,3,5; outDone one cycle after.
- len=127 → PHR nibbles F,7; exactly 266 writes; outDone once.
- inFifoFull=1 for 3 cycles during SFD → no writes while full, sequence unchanged, frame ends 3 cycles later.
- inPayValid gap of 5 cycles mid-payload, len=2 → outPayReady stays 1; payload order preserved; 16 writes total.
- inStart with inLength=0 → outError pulse one cycle, no writes, outBusy stays 0. A second inStart during PAYLOAD is ignored.
- inReset=1 during PHR → next cycle all outputs 0 and IDLE. A fresh inStart then produces a full, correct frame.

Source files
------------

// File: rtl/zigbee_pkg.sv
// Shared ZigBee transmit-path definitions: framer state encoding, PPDU
// framing constants and small helpers used by the framing stage.
package zigbee_pkg;

    typedef enum logic [2:0] {
        FR_IDLE     = 3'd0,
        FR_PREAMBLE = 3'd1,
        FR_SFD      = 3'd2,
        FR_PHR      = 3'd3,
        FR_PAYLOAD  = 3'd4,
        FR_DONE     = 3'd5
    } framer_state_e;

    localparam logic [7:0]  SFD_DEFAULT              = 8'hA7;
    localparam int unsigned PREAMBLE_NIBBLES_DEFAULT = 8;
    localparam int unsigned MAX_PSDU_LEN             = 127;

    // Payload length in bytes -> number of 4-bit symbols on air.
    function automatic logic [7:0] payload_nibbles(input logic [6:0] len);
        return {len, 1'b0};
    endfunction

    function automatic framer_state_e framer_next(input framer_state_e st);
        case (st)
            FR_PREAMBLE: return FR_SFD;
            FR_SFD:      return FR_PHR;
            FR_PHR:      return FR_PAYLOAD;
            FR_PAYLOAD:  return FR_DONE;
            default:     return FR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ppdu_framer.sv
// Transmit framing stage: writes preamble, SFD, PHR and the payload nibbles
// of one 802.15.4 PPDU into the inFIFO, honouring its full flag.
module ppdu_framer
    import zigbee_pkg::*;
#(
    parameter int unsigned PREAMBLE_NIBBLES = PREAMBLE_NIBBLES_DEFAULT,
    parameter logic [7:0]  SFD              = SFD_DEFAULT
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic [6:0] inLength,
    input  logic [3:0] inPayData,
    input  logic       inPayValid,
    output logic       outPayReady,
    input  logic       inFifoFull,
    output logic [3:0] outData,
    output logic       outWriteEnable,
    output logic       outBusy,
    output logic       outDone,
    output logic       outError
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_NIBBLES - 1);

    framer_state_e r_state;
    framer_state_e w_state_next;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_next;
    logic [6:0]    r_len;
    logic [6:0]    w_len_next;
    logic          r_error;
    logic          w_error_next;
    logic          w_write;
    logic          w_last;
    logic          w_pay_ready;
    logic [3:0]    w_data;
    logic [7:0]    w_pay_last;

    assign w_pay_last = payload_nibbles(r_len) - 8'd1;

    // Next-state, counter update and symbol mux; counter only moves on a real write.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_len_next   = r_len;
        w_error_next = 1'b0;
        w_write      = 1'b0;
        w_last       = 1'b0;
        w_pay_ready  = 1'b0;
        w_data       = 4'h0;
        case (r_state)
            FR_IDLE: begin
                if (inStart) begin
                    if (inLength != 7'd0) begin
                        w_state_next = FR_PREAMBLE;
                        w_len_next   = inLength;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end else begin
                    w_state_next = FR_IDLE;
                end
            end
            FR_PREAMBLE: begin
                w_write = ~inFifoFull;
                w_last  = (r_cnt == PRE_LAST);
            end
            FR_SFD: begin
                w_write = ~inFifoFull;
                w_data  = (r_cnt == 8'd0) ? SFD[3:0] : SFD[7:4];
                w_last  = (r_cnt == 8'd1);
            end
            FR_PHR: begin
                w_write = ~inFifoFull;
                w_data  = (r_cnt == 8'd0) ? r_len[3:0] : {1'b0, r_len[6:4]};
                w_last  = (r_cnt == 8'd1);
            end
            FR_PAYLOAD: begin
                w_pay_ready = ~inFifoFull;
                w_write     = inPayValid & ~inFifoFull;
                w_data      = inPayData;
                w_last      = (r_cnt == w_pay_last);
            end
            FR_DONE: begin
                w_state_next = FR_IDLE;
            end
            default: begin
                w_state_next = FR_IDLE;
            end
        endcase
        if (w_write) begin
            if (w_last) begin
                w_cnt_next   = 8'd0;
                w_state_next = framer_next(r_state);
            end else begin
                w_cnt_next = r_cnt + 8'd1;
            end
        end else begin
            w_cnt_next = w_cnt_next;
        end
    end

    // State, counter, length and error-pulse registers.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            r_state <= FR_IDLE;
            r_cnt   <= 8'd0;
            r_len   <= 7'd0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_len   <= w_len_next;
            r_error <= w_error_next;
        end
    end

    assign outData        = w_data;
    assign outWriteEnable = w_write;
    assign outPayReady    = w_pay_ready;
    assign outBusy        = (r_state != FR_IDLE);
    assign outDone        = (r_state == FR_DONE);
    assign outError       = r_error;

endmodule

// File: tb/tb_ppdu_framer.sv
// Scoreboard bench for ppdu_framer: stimulus pushes expected symbols, a
// negedge monitor pops and compares every FIFO write.
`timescale 1ns/1ps
module tb_ppdu_framer;

    logic       inClock = 1'b0;
    logic       inReset;
    logic       inStart;
    logic [6:0] inLength;
    logic [3:0] inPayData;
    logic       inPayValid;
    logic       outPayReady;
    logic       inFifoFull;
    logic [3:0] outData;
    logic       outWriteEnable;
    logic       outBusy;
    logic       outDone;
    logic       outError;

    ppdu_framer dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inStart        (inStart),
        .inLength       (inLength),
        .inPayData      (inPayData),
        .inPayValid     (inPayValid),
        .outPayReady    (outPayReady),
        .inFifoFull     (inFifoFull),
        .outData        (outData),
        .outWriteEnable (outWriteEnable),
        .outBusy        (outBusy),
        .outDone        (outDone),
        .outError       (outError)
    );

    always #5 inClock = ~inClock;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    logic [3:0] sb[$];
    logic [3:0] src[$];
    int full_lo = -1, full_hi = -1, gap_lo = -1, gap_hi = -1;
    int n_wr = 0, first_wr = -1, last_wr = -1, n_done = 0, n_err = 0;
    int t_start = 0;
    int d0, e0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Payload source and FIFO-full driver, updated just after each edge.
    initial forever begin
        @(posedge inClock);
        if (inPayValid === 1'b1 && outPayReady === 1'b1 && src.size() != 0)
            void'(src.pop_front());
        cyc = cyc + 1;
        #1;
        inFifoFull = (cyc >= full_lo) && (cyc <= full_hi);
        inPayValid = (src.size() != 0) && !((cyc >= gap_lo) && (cyc <= gap_hi));
        inPayData  = (src.size() != 0) ? src[0] : 4'h0;
    end

    // Monitor: every write must match the head of the scoreboard.
    initial forever begin
        @(negedge inClock);
        if (outWriteEnable === 1'b1) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            chk("write_while_full", inFifoFull, 1'b0);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got %0h expected no write (cycle %0d)", outData, cyc);
            end else begin
                chk("symbol", outData, sb.pop_front());
            end
        end
        if (outDone === 1'b1)  n_done++;
        if (outError === 1'b1) n_err++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic start(input logic [6:0] len, input logic [3:0] base, input logic [3:0] step);
        logic [3:0] nib;
        @(posedge inClock); #1;
        inStart  = 1'b1;
        inLength = len;
        t_start  = cyc + 1;
        if (len != 7'd0) begin
            repeat (8) sb.push_back(4'h0);
            sb.push_back(4'h7);
            sb.push_back(4'hA);
            sb.push_back(len[3:0]);
            sb.push_back({1'b0, len[6:4]});
            nib = base;
            for (int i = 0; i < 2 * int'(len); i++) begin
                sb.push_back(nib);
                src.push_back(nib);
                nib = nib + step;
            end
        end
        n_wr = 0; first_wr = -1; last_wr = -1;
        @(posedge inClock); #1;
        inStart = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        int got;
        got = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge inClock);
            if (outDone === 1'b1) begin
                got = cyc;
                break;
            end
        end
        chk(name, got, exp_cyc);
    endtask

    task automatic frame_checks(input int len, input int extra);
        chk("write_count", n_wr, 12 + 2 * len);
        chk("first_write_cycle", first_wr, t_start);
        chk("last_write_cycle", last_wr, t_start + 11 + 2 * len + extra);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic wait_neg(input int c);
        do @(negedge inClock); while (cyc < c);
    endtask

    initial begin
        inReset = 1'b1; inStart = 1'b0; inLength = 7'd0;
        inPayValid = 1'b0; inPayData = 4'h0; inFifoFull = 1'b0;
        repeat (3) @(posedge inClock);
        @(negedge inClock);
        chk("rst_we", outWriteEnable, 1'b0);
        chk("rst_busy", outBusy, 1'b0);
        chk("rst_done", outDone, 1'b0);
        chk("rst_error", outError, 1'b0);
        chk("rst_data", outData, 4'h0);
        chk("rst_ready", outPayReady, 1'b0);
        @(posedge inClock); #1;
        inReset = 1'b0;
        d0 = n_done;

        // len=1, payload 3,5: 0x8,7,A,1,0,3,5 back-to-back
        start(7'd1, 4'h3, 4'h2);
        @(negedge inClock);
        chk("busy_after_start", outBusy, 1'b1);
        wait_done("done_len1", t_start + 14);
        frame_checks(1, 0);

        // len=127 started in the IDLE cycle right after DONE, with an ignored start
        start(7'd127, 4'h0, 4'h1);
        while (cyc < t_start + 20) begin @(posedge inClock); #1; end
        inStart = 1'b1; inLength = 7'd5;
        @(posedge inClock); #1;
        inStart = 1'b0;
        wait_done("done_len127", t_start + 12 + 254);
        frame_checks(127, 0);
        repeat (3) @(negedge inClock);
        chk("done_pulses", n_done - d0, 2);
        chk("no_error_so_far", n_err, 0);

        // FIFO full for 3 cycles at the start of SFD
        start(7'd1, 4'hC, 4'h1);
        full_lo = t_start + 8; full_hi = t_start + 10;
        wait_neg(t_start + 9);
        chk("stall_no_write", outWriteEnable, 1'b0);
        wait_done("done_stall", t_start + 17);
        frame_checks(1, 3);
        full_lo = -1; full_hi = -1;

        // payload valid gap of 5 cycles after the first payload nibble
        start(7'd2, 4'h1, 4'h1);
        gap_lo = t_start + 13; gap_hi = t_start + 17;
        wait_neg(t_start + 15);
        chk("gap_ready", outPayReady, 1'b1);
        chk("gap_no_write", outWriteEnable, 1'b0);
        wait_done("done_gap", t_start + 21);
        frame_checks(2, 5);
        gap_lo = -1; gap_hi = -1;

        // zero length is rejected with a one-cycle error pulse
        start(7'd0, 4'h0, 4'h0);
        @(negedge inClock);
        chk("err_pulse", outError, 1'b1);
        chk("err_busy", outBusy, 1'b0);
        @(negedge inClock);
        chk("err_pulse_end", outError, 1'b0);
        repeat (3) @(negedge inClock);
        chk("err_no_writes", n_wr, 0);
        chk("err_count", n_err, 1);

        // reset during PHR abandons the frame
        start(7'd3, 4'h2, 4'h3);
        while (cyc < t_start + 10) begin @(posedge inClock); #1; end
        inReset = 1'b1;
        @(posedge inClock); #1;
        inReset = 1'b0;
        @(negedge inClock);
        chk("rstmid_busy", outBusy, 1'b0);
        chk("rstmid_we", outWriteEnable, 1'b0);
        chk("rstmid_data", outData, 4'h0);
        chk("rstmid_ready", outPayReady, 1'b0);
        chk("rstmid_remaining", sb.size(), 7);
        sb.delete(); src.delete();
        d0 = n_done; e0 = n_err;
        repeat (4) @(negedge inClock);
        chk("rstmid_no_done", n_done - d0, 0);
        chk("rstmid_no_error", n_err - e0, 0);
        chk("rstmid_writes", n_wr, 11);

        start(7'd3, 4'h5, 4'h7);
        wait_done("done_after_reset", t_start + 18);
        frame_checks(3, 0);

        repeat (3) @(negedge inClock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
